// File: rtl/stream_rsc_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : stream_rsc_encoder_if                                          |
// | Brief     : Bit-in / symbol-out handshake bundle of the RSC encoder.       |
// |             The out_llr member exists only when RSC_LLR_OUT_EN is defined. |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface stream_rsc_encoder_if #(
  parameter int BITS_PER_SYMBOL = 2
`ifdef RSC_LLR_OUT_EN
  ,
  parameter int BITS = 16
`endif
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_bit;
  logic                       out_valid;
  logic                       out_ready;
  logic [BITS_PER_SYMBOL-1:0] out_symbol;
  logic                       out_first;
  logic                       out_last;
`ifdef RSC_LLR_OUT_EN
  logic [BITS_PER_SYMBOL-1:0][BITS-1:0] out_llr;
`endif

  // slave: the encoder; master: the environment feeding bits and taking symbols
  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_symbol, out_first, out_last
`ifdef RSC_LLR_OUT_EN
    ,
    output out_llr
`endif
  );

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_symbol, out_first, out_last
`ifdef RSC_LLR_OUT_EN
    ,
    input  out_llr
`endif
  );
endinterface
`default_nettype wire

// File: rtl/stream_rsc_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stream_rsc_encoder                                              |
// | Brief    : Streaming RSC encoder, {parity, systematic} per bit plus MEMORY |
// |            terminating tail symbols per block. Optional macro             |
// |            RSC_LLR_OUT_EN adds a registered BPSK half-precision LLR output.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module stream_rsc_encoder #(
  parameter int              SYMBOLS         = 10,
  parameter int              MEMORY          = 2,
  parameter logic [MEMORY:0] FEEDBACK        = 3'b111,
  parameter logic [MEMORY:0] FEEDFORWARD     = 3'b101,
  parameter int              BITS            = 16,
  parameter int              BITS_PER_SYMBOL = 2
) (
  input  wire logic            clk,
  input  wire logic            rstn,
  stream_rsc_encoder_if.slave  bus
);

  localparam int         c_CNT_MAX = (SYMBOLS > MEMORY) ? SYMBOLS : MEMORY;
  localparam int         c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [0:0] c_DATA    = 1'b0;
  localparam logic [0:0] c_TAIL    = 1'b1;

  generate
    if (BITS_PER_SYMBOL != 2) begin : g_bad_bps
      $error("stream_rsc_encoder: BITS_PER_SYMBOL must be 2");
    end
    if (MEMORY < 1) begin : g_bad_memory
      $error("stream_rsc_encoder: MEMORY must be at least 1");
    end
    if (FEEDBACK[0] != 1'b1) begin : g_bad_feedback
      $error("stream_rsc_encoder: FEEDBACK bit 0 must be 1");
    end
    if (SYMBOLS < 1) begin : g_bad_symbols
      $error("stream_rsc_encoder: SYMBOLS must be at least 1");
    end
    if (BITS < 2) begin : g_bad_bits
      $error("stream_rsc_encoder: BITS must be at least 2");
    end
  endgenerate

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [c_CNT_W-1:0] w_remaining;
  logic [MEMORY-1:0]  r_sr;        // bit i-1 holds r[i]
  logic [MEMORY-1:0]  w_sr_nxt;
  logic               w_fb;
  logic               w_u;
  logic               w_a;
  logic               w_p;
  logic               w_can_step;
  logic               w_in_ready;
  logic               w_fire;
  logic               w_first;
  logic               w_last;

  logic               r_out_valid;
  logic [1:0]         r_out_sym;
  logic               r_out_first;
  logic               r_out_last;

  assign w_fb = ^(FEEDBACK[MEMORY:1] & r_sr);
  assign w_a  = w_u ^ w_fb;
  assign w_p  = (FEEDFORWARD[0] & w_a) ^ (^(FEEDFORWARD[MEMORY:1] & r_sr));

  generate
    if (MEMORY == 1) begin : g_shift_m1
      assign w_sr_nxt = w_a;
    end else begin : g_shift
      assign w_sr_nxt = {r_sr[MEMORY-2:0], w_a};
    end
  endgenerate

  // r_cnt == 0 in DATA marks "no bit of this block accepted yet"
  assign w_remaining = (r_cnt == '0) ? c_CNT_W'(SYMBOLS) : r_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= c_DATA;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_fire) begin
        r_sr <= w_sr_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_fire) begin
      case (r_state)
        c_DATA: begin
          if (w_remaining == c_CNT_W'(1)) begin
            w_state_nxt = c_TAIL;
            w_cnt_nxt   = c_CNT_W'(MEMORY);
          end else begin
            w_cnt_nxt = w_remaining - c_CNT_W'(1);
          end
        end
        default: begin
          if (r_cnt == c_CNT_W'(1)) begin
            w_state_nxt = c_DATA;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - c_CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Tail steps feed u = feedback so a = 0, flushing the register to zero
  always_comb begin
    w_can_step = !r_out_valid || bus.out_ready;
    w_in_ready = 1'b0;
    w_fire     = 1'b0;
    w_u        = 1'b0;
    w_first    = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      c_DATA: begin
        w_in_ready = rstn && w_can_step;
        w_fire     = w_in_ready && bus.in_valid;
        w_u        = bus.in_bit;
        w_first    = (r_cnt == '0);
      end
      default: begin
        w_fire = w_can_step;
        w_u    = w_fb;
        w_last = (r_cnt == c_CNT_W'(1));
      end
    endcase
  end

`ifdef RSC_LLR_OUT_EN
  localparam logic [BITS-1:0] c_LLR_POS = BITS'(16'h3C00);
  localparam logic [BITS-1:0] c_LLR_NEG = BITS'(16'hBC00);
  logic [BITS_PER_SYMBOL-1:0][BITS-1:0] r_out_llr;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_sym   <= '0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
`ifdef RSC_LLR_OUT_EN
      r_out_llr   <= '0;
`endif
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_sym   <= {w_p, w_u};
      r_out_first <= w_first;
      r_out_last  <= w_last;
`ifdef RSC_LLR_OUT_EN
      r_out_llr[0] <= w_u ? c_LLR_NEG : c_LLR_POS;
      r_out_llr[1] <= w_p ? c_LLR_NEG : c_LLR_POS;
`endif
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_symbol = r_out_sym;
  assign bus.out_first  = r_out_first;
  assign bus.out_last   = r_out_last;
`ifdef RSC_LLR_OUT_EN
  assign bus.out_llr    = r_out_llr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_rsc_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stream_rsc_encoder                                           |
// | Brief    : Directed bench for stream_rsc_encoder (SYMBOLS=4, g0=7, g1=5).  |
// |            Honours RSC_LLR_OUT_EN when defined.                            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_stream_rsc_encoder;

  localparam int SYMBOLS = 4;

  typedef struct {
    logic [1:0]  sym;
    logic        first;
    logic        last;
    int          cyc;
    logic [31:0] llr;
  } rec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  rec_t q[$];

  // Hand-derived: 1,0,1,1 -> 11,10,01,01 then tail 10,11
  logic [1:0]  exp_sym [6] = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b11};
  // {parity LLR, systematic LLR}
  logic [31:0] exp_llr [6] = '{32'hBC00BC00, 32'hBC003C00, 32'h3C00BC00,
                               32'h3C00BC00, 32'hBC003C00, 32'hBC00BC00};
  logic [3:0]  blk1    = 4'b1101;   // bit k = k-th bit sent: 1,0,1,1

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef RSC_LLR_OUT_EN
  stream_rsc_encoder_if #(.BITS_PER_SYMBOL(2), .BITS(16)) bus ();
`else
  stream_rsc_encoder_if #(.BITS_PER_SYMBOL(2)) bus ();
`endif

  stream_rsc_encoder #(.SYMBOLS(SYMBOLS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      rec_t r;
      r.sym   = bus.out_symbol;
      r.first = bus.out_first;
      r.last  = bus.out_last;
      r.cyc   = cyc;
`ifdef RSC_LLR_OUT_EN
      r.llr   = bus.out_llr;
`else
      r.llr   = '0;
`endif
      q.push_back(r);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    @(negedge clk);
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_blk1();
    for (int k = 0; k < 4; k++) send_bit(blk1[k]);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input logic zero);
    for (int i = 0; i < 6; i++) begin
      if (q.size() == 0) begin
        check($sformatf("%s_missing%0d", tag, i), 0, 1);
      end else begin
        rec_t r = q.pop_front();
        check($sformatf("%s_sym%0d", tag, i), 32'(r.sym), zero ? 32'd0 : 32'(exp_sym[i]));
        check($sformatf("%s_first%0d", tag, i), 32'(r.first), 32'(i == 0));
        check($sformatf("%s_last%0d", tag, i), 32'(r.last), 32'(i == 5));
`ifdef RSC_LLR_OUT_EN
        check($sformatf("%s_llr%0d", tag, i), r.llr, zero ? 32'h3C003C00 : exp_llr[i]);
`endif
      end
    end
  endtask

  initial begin
    int lo;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_symbol", 32'(bus.out_symbol), 0);
    check("rst_out_first", 32'(bus.out_first), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
`ifdef RSC_LLR_OUT_EN
    check("rst_out_llr", bus.out_llr, 0);
`endif
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Scenario 1: basic block
    send_blk1();
    bus.in_valid = 1'b0;
    lo = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      lo++;
    end
    check("tail_in_ready_low", lo, 2);
    drain();
    check("s1_state_zero", 32'(dut.r_sr), 0);
    check("s1_count", q.size(), 6);
    check_frame("s1", 1'b0);

    // Scenario 2: 3-cycle stall on the third symbol
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.in_bit    = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_valid%0d", i), 32'(bus.out_valid), 1);
      check($sformatf("stall_sym%0d", i), 32'(bus.out_symbol), 32'b01);
      check($sformatf("stall_in_ready%0d", i), 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send_bit(1'b1);
    drain();
    check("s2_count", q.size(), 6);
    check_frame("s2", 1'b0);

    // Scenario 3: two blocks back-to-back
    send_blk1();
    for (int k = 0; k < 4; k++) send_bit(1'b0);
    drain();
    check("b2b_count", q.size(), 12);
    if (q.size() >= 12) check("b2b_span", q[11].cyc - q[0].cyc, 11);
    check_frame("b2b_blk1", 1'b0);
    check_frame("b2b_blk2", 1'b1);

    // Scenario 4: reset after two accepted bits
    send_bit(1'b1);
    send_bit(1'b0);
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_tail", q.size(), 0);
    send_blk1();
    drain();
    check_frame("s4", 1'b0);

    // Scenario 5: in_valid toggling
    for (int k = 0; k < 4; k++) begin
      send_bit(blk1[k]);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    drain();
    check("s5_count", q.size(), 6);
    check_frame("s5", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
